// File: rtl/banked_dpram.sv
// Banked true-dual-port memory: NUM_BANKS banks of 2**BANK_AW words, 1-cycle registered reads,
// sticky out-of-range flags and port-A-wins write collision handling.
module banked_dpram #(
    parameter int DW        = 18,
    parameter int BANK_AW   = 10,
    parameter int NUM_BANKS = 11,
    parameter int AW        = 14,
    parameter int WR_FIRST  = 0
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    output logic [DW-1:0] douta,
    input  logic          enb,
    input  logic          web,
    input  logic [AW-1:0] addrb,
    input  logic [DW-1:0] dinb,
    output logic [DW-1:0] doutb,
    input  logic          err_clr,
    output logic          err_a,
    output logic          err_b,
    output logic          collide
);
    localparam int BSW   = AW - BANK_AW;
    localparam int DEPTH = 2 ** BANK_AW;
    // One extra bit so NUM_BANKS == 2**BSW does not wrap to zero.
    localparam logic [BSW:0] NB = (BSW + 1)'(NUM_BANKS);

    logic [BSW-1:0]     bank_a, bank_b, sel_a, sel_b;
    logic [BANK_AW-1:0] word_a, word_b;
    logic               in_a, in_b, acc_a, acc_b, wr_a, wr_b, clash;
    logic               zero_a, zero_b;
    logic [DW-1:0]      rd_a [NUM_BANKS];
    logic [DW-1:0]      rd_b [NUM_BANKS];

    assign bank_a = addra[AW-1:BANK_AW];
    assign bank_b = addrb[AW-1:BANK_AW];
    assign word_a = addra[BANK_AW-1:0];
    assign word_b = addrb[BANK_AW-1:0];
    assign in_a   = {1'b0, bank_a} < NB;
    assign in_b   = {1'b0, bank_b} < NB;
    assign acc_a  = ena & rst_n;
    assign acc_b  = enb & rst_n;
    assign wr_a   = acc_a & wea & in_a;
    assign clash  = wr_a & acc_b & web & in_b & (addra == addrb);
    assign wr_b   = acc_b & web & in_b & ~clash;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        localparam logic [BSW-1:0] IDX = BSW'(g);
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] q_a, q_b;

        always_ff @(posedge clka) begin
            if (wr_a && bank_a == IDX) mem[word_a] <= dina;
            if (wr_b && bank_b == IDX) mem[word_b] <= dinb;
            // Non-blocking reads see the pre-edge word, so cross-port reads are always read-first.
            if (acc_a && bank_a == IDX) q_a <= (WR_FIRST != 0 && wr_a) ? dina : mem[word_a];
            if (acc_b && bank_b == IDX) q_b <= (WR_FIRST != 0 && wr_b) ? dinb : mem[word_b];
        end

        assign rd_a[g] = q_a;
        assign rd_b[g] = q_b;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            sel_a   <= '0;
            sel_b   <= '0;
            zero_a  <= 1'b1;
            zero_b  <= 1'b1;
            err_a   <= 1'b0;
            err_b   <= 1'b0;
            collide <= 1'b0;
        end else begin
            if (acc_a) begin
                sel_a  <= bank_a;
                zero_a <= ~in_a;
            end
            if (acc_b) begin
                sel_b  <= bank_b;
                zero_b <= ~in_b;
            end
            err_a   <= (acc_a & ~in_a) | (err_a & ~err_clr);
            err_b   <= (acc_b & ~in_b) | (err_b & ~err_clr);
            collide <= clash;
        end
    end

    // Output mux follows the registered bank index; zero flag covers reset and out-of-range reads.
    always_comb begin
        douta = '0;
        doutb = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (!zero_a && sel_a == BSW'(b)) douta = rd_a[b];
            if (!zero_b && sel_b == BSW'(b)) doutb = rd_b[b];
        end
    end
endmodule
